// File: rtl/frame_sequencer.sv
// frame_sequencer: schedules color-frame and white-value runs on the LED
// string drivers. Only one driver is active at a time, and every run is
// followed by a latch gap.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   IDLE         | waiting for a full color frame or a pending white value
//   COLOR_START  | color_go issued, waiting for color_busy to rise
//   COLOR_RUN    | color driver active, waiting for color_busy to fall
//   WHITE_START  | white_go issued, waiting for white_busy to rise
//   WHITE_RUN    | white driver active, waiting for white_busy to fall
//   LATCH        | inter-frame latch gap, both drivers blanked
module frame_sequencer #(
  parameter int FIFO_ADDR_WIDTH = 13,
  parameter int FRAME_WORDS     = 4096,
  parameter int LATCH_CYCLES    = 6000,
  parameter int START_TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [FIFO_ADDR_WIDTH:0] fifo_full_count,
  input  logic                     white_req,
  input  logic                     color_busy,
  input  logic                     white_busy,
  output logic                     color_go,
  output logic                     white_go,
  output logic                     hold,
  output logic [15:0]              frame_count,
  output logic                     start_err,
  output logic [2:0]               state
);

  localparam int AW1 = FIFO_ADDR_WIDTH + 1;
  localparam int LW  = $clog2(LATCH_CYCLES + 1);
  localparam int TW  = $clog2(START_TIMEOUT + 1);

  localparam logic [FIFO_ADDR_WIDTH:0] FRAME_THRESH = AW1'(FRAME_WORDS);
  localparam logic [LW-1:0]            LATCH_LOAD   = LW'(LATCH_CYCLES);
  // The START state counts down from START_TIMEOUT-1 so that the timeout
  // fires on the START_TIMEOUT-th cycle spent waiting for busy.
  localparam logic [TW-1:0]            TMO_LOAD     = TW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_COLOR_START = 3'd1,
    ST_COLOR_RUN   = 3'd2,
    ST_WHITE_START = 3'd3,
    ST_WHITE_RUN   = 3'd4,
    ST_LATCH       = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          color_go_q, color_go_d;
  logic          white_go_q, white_go_d;
  logic          hold_q, hold_d;
  logic          start_err_q, start_err_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          white_pend_q, white_pend_d;
  logic          last_white_q, last_white_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] latch_q, latch_d;

  logic color_ready;
  logic white_ready;

  // State and output registers; reset abandons any run without side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      color_go_q    <= 1'b0;
      white_go_q    <= 1'b0;
      hold_q        <= 1'b1;
      start_err_q   <= 1'b0;
      frame_count_q <= '0;
      white_pend_q  <= 1'b0;
      last_white_q  <= 1'b1;
      tmo_q         <= '0;
      latch_q       <= '0;
    end else begin
      state_q       <= state_d;
      color_go_q    <= color_go_d;
      white_go_q    <= white_go_d;
      hold_q        <= hold_d;
      start_err_q   <= start_err_d;
      frame_count_q <= frame_count_d;
      white_pend_q  <= white_pend_d;
      last_white_q  <= last_white_d;
      tmo_q         <= tmo_d;
      latch_q       <= latch_d;
    end
  end

  // Next-state, arbitration, timers and registered-output next values.
  always_comb begin
    state_d       = state_q;
    color_go_d    = 1'b0;
    white_go_d    = 1'b0;
    start_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    last_white_d  = last_white_q;
    tmo_d         = tmo_q;
    latch_d       = latch_q;

    // A request arriving in the same cycle as white_go must not be lost.
    white_pend_d = white_req | (white_pend_q & ~white_go_q);

    color_ready = enable && (fifo_full_count >= FRAME_THRESH);
    white_ready = enable && white_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (color_ready && (!white_ready || last_white_q)) begin
          state_d    = ST_COLOR_START;
          color_go_d = 1'b1;
          tmo_d      = TMO_LOAD;
        end else if (white_ready) begin
          state_d    = ST_WHITE_START;
          white_go_d = 1'b1;
          tmo_d      = TMO_LOAD;
        end
      end
      ST_COLOR_START: begin
        if (color_busy) begin
          state_d = ST_COLOR_RUN;
          tmo_d   = '0;
        end else if (tmo_q == '0) begin
          state_d      = ST_LATCH;
          start_err_d  = 1'b1;
          last_white_d = 1'b0;
          latch_d      = LATCH_LOAD;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_COLOR_RUN: begin
        if (!color_busy) begin
          state_d       = ST_LATCH;
          frame_count_d = frame_count_q + 16'd1;
          last_white_d  = 1'b0;
          latch_d       = LATCH_LOAD;
        end
      end
      ST_WHITE_START: begin
        if (white_busy) begin
          state_d = ST_WHITE_RUN;
          tmo_d   = '0;
        end else if (tmo_q == '0) begin
          state_d      = ST_LATCH;
          start_err_d  = 1'b1;
          last_white_d = 1'b1;
          latch_d      = LATCH_LOAD;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      ST_WHITE_RUN: begin
        if (!white_busy) begin
          state_d      = ST_LATCH;
          last_white_d = 1'b1;
          latch_d      = LATCH_LOAD;
        end
      end
      ST_LATCH: begin
        if (latch_q <= LW'(1)) begin
          state_d = ST_IDLE;
          latch_d = '0;
        end else begin
          latch_d = latch_q - LW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    hold_d = (state_d == ST_IDLE) || (state_d == ST_LATCH);
  end

  assign color_go    = color_go_q;
  assign white_go    = white_go_q;
  assign hold        = hold_q;
  assign start_err   = start_err_q;
  assign frame_count = frame_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed stimulus pushes expected go/start_err
// events into a scoreboard queue; a negedge monitor pops and compares them.
// A second instance with a one-cycle latch gap exercises frame_count wrap.
module tb_frame_sequencer;

  localparam int AW = 13;
  localparam logic [1:0] K_COLOR = 2'd0;
  localparam logic [1:0] K_WHITE = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW:0]   fifo_full_count = '0;
  logic          white_req = 1'b0;
  logic          color_busy = 1'b0;
  logic          white_busy = 1'b0;
  logic          color_go, white_go, hold, start_err;
  logic [15:0]   frame_count;
  logic [2:0]    state;

  always #5 clk = ~clk;

  frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_full_count(fifo_full_count), .white_req(white_req),
    .color_busy(color_busy), .white_busy(white_busy),
    .color_go(color_go), .white_go(white_go), .hold(hold),
    .frame_count(frame_count), .start_err(start_err), .state(state)
  );

  // Wrap instance: short latch gap, color driver modelled as an instant responder.
  logic          clk_w = 1'b0;
  logic          reset_w_n = 1'b0;
  logic          enable_w = 1'b1;
  logic [AW:0]   fifo_w = 14'd4096;
  logic          white_req_w = 1'b0;
  logic          white_busy_w = 1'b0;
  logic          color_busy_w;
  logic          color_go_w, white_go_w, hold_w, start_err_w;
  logic [15:0]   fc_w;
  logic [2:0]    state_w;
  bit            wrap_done = 1'b0;

  always #1 clk_w = ~clk_w;
  assign color_busy_w = (state_w == 3'd1);

  frame_sequencer #(.LATCH_CYCLES(1)) dut_wrap (
    .clk(clk_w), .reset_n(reset_w_n), .enable(enable_w),
    .fifo_full_count(fifo_w), .white_req(white_req_w),
    .color_busy(color_busy_w), .white_busy(white_busy_w),
    .color_go(color_go_w), .white_go(white_go_w), .hold(hold_w),
    .frame_count(fc_w), .start_err(start_err_w), .state(state_w)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] fc;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [15:0] fc);
    ev_t e;
    e.kind = k;
    e.fc   = fc;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic [1:0] k);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at %0t, expected no event", k, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.fc !== frame_count) begin
        n_fail++;
        $display("FAIL event_order: got kind %0d fc %0h, expected kind %0d fc %0h",
                 k, frame_count, e.kind, e.fc);
      end
    end
    if (k != K_ERR) chk("go_with_hold_low", {31'd0, hold}, 32'd0);
  endtask

  // Scoreboard monitor: every go or start_err pulse consumes one expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (color_go)  check_ev(K_COLOR);
      if (white_go)  check_ev(K_WHITE);
      if (start_err) check_ev(K_ERR);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_state",     {29'd0, state},       32'd0);
    chk("rst_hold",      {31'd0, hold},        32'd1);
    chk("rst_color_go",  {31'd0, color_go},    32'd0);
    chk("rst_white_go",  {31'd0, white_go},    32'd0);
    chk("rst_start_err", {31'd0, start_err},   32'd0);
    chk("rst_frame_cnt", {16'd0, frame_count}, 32'd0);
    enable = 1'b0; fifo_full_count = '0; white_req = 1'b0;
    color_busy = 1'b0; white_busy = 1'b0;
    #2 reset_n = 1'b1;
    step();
  endtask

  task automatic wait_go(input string name, input bit white, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      seen = white ? white_go : color_go;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  // From the go cycle: busy high for len cycles, then low; ends on LATCH entry.
  task automatic do_run(input string name, input bit white, input int len,
                        input logic [15:0] exp_fc, input bit req_at_go, input bit req_mid);
    if (white) white_busy = 1'b1; else color_busy = 1'b1;
    for (int i = 0; i < len; i++) begin
      white_req = (req_at_go && i == 0) || (req_mid && i == 2);
      step();
    end
    white_req = 1'b0;
    if (white) white_busy = 1'b0; else color_busy = 1'b0;
    step();
    chk({name, "_latch_state"}, {29'd0, state},       32'd5);
    chk({name, "_latch_hold"},  {31'd0, hold},        32'd1);
    chk({name, "_frame_cnt"},   {16'd0, frame_count}, {16'd0, exp_fc});
  endtask

  task automatic count_gos(input int n, output int gos);
    gos = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (color_go || white_go) gos++;
    end
  endtask

  initial begin : wrap_proc
    int cyc;
    repeat (3) @(posedge clk_w);
    @(negedge clk_w) reset_w_n = 1'b1;
    cyc = 0;
    while (fc_w != 16'hFFFF && cyc < 270000) begin
      @(negedge clk_w);
      cyc++;
    end
    chk("wrap_reach_ffff", {16'd0, fc_w}, 32'h0000FFFF);
    cyc = 0;
    while (fc_w == 16'hFFFF && cyc < 20) begin
      @(negedge clk_w);
      cyc++;
    end
    chk("wrap_to_zero", {16'd0, fc_w}, 32'd0);
    wrap_done = 1'b1;
  end

  initial begin : main_proc
    int gos;
    int w;

    // Color frame, latch gap, threshold boundary
    do_reset();
    enable = 1'b1;
    fifo_full_count = 14'd4096;
    expect_ev(K_COLOR, 16'd0);
    wait_go("color_go_latency", 1'b0, 1);
    chk("color_start_state", {29'd0, state}, 32'd1);
    do_run("color1", 1'b0, 100, 16'd1, 1'b0, 1'b0);
    count_gos(5999, gos);
    chk("latch_no_go", gos, 32'd0);
    chk("latch_last_cycle", {29'd0, state}, 32'd5);
    fifo_full_count = 14'd4095;
    step();
    chk("latch_to_idle", {29'd0, state}, 32'd0);
    count_gos(10000, gos);
    chk("thresh_4095_no_go", gos, 32'd0);
    chk("thresh_4095_idle", {29'd0, state}, 32'd0);
    expect_ev(K_COLOR, 16'd1);
    fifo_full_count = 14'd8192;
    wait_go("thresh_8192_go", 1'b0, 1);
    do_run("color2", 1'b0, 5, 16'd2, 1'b0, 1'b0);
    do_reset();

    // Arbitration: color, white, color, white (req at go), white; reset mid white run
    enable = 1'b1;
    expect_ev(K_COLOR, 16'd0);
    expect_ev(K_WHITE, 16'd1);
    expect_ev(K_COLOR, 16'd1);
    expect_ev(K_WHITE, 16'd2);
    expect_ev(K_WHITE, 16'd2);
    white_req = 1'b1;
    fifo_full_count = 14'd4096;
    step();
    white_req = 1'b0;
    chk("arb1_color_go", {31'd0, color_go}, 32'd1);
    do_run("arb1", 1'b0, 8, 16'd1, 1'b0, 1'b0);
    wait_go("arb2_white_go", 1'b1, 6010);
    do_run("arb2", 1'b1, 8, 16'd1, 1'b0, 1'b1);
    wait_go("arb3_color_go", 1'b0, 6010);
    do_run("arb3", 1'b0, 8, 16'd2, 1'b0, 1'b0);
    wait_go("arb4_white_go", 1'b1, 6010);
    fifo_full_count = '0;
    do_run("arb4", 1'b1, 8, 16'd2, 1'b1, 1'b0);
    wait_go("arb5_white_go", 1'b1, 6010);
    white_busy = 1'b1;
    step(5);
    white_req = 1'b1;
    step();
    white_req = 1'b0;
    chk("mid_white_run", {29'd0, state}, 32'd4);
    do_reset();
    enable = 1'b1;
    count_gos(20, gos);
    chk("pend_cleared_by_reset", gos, 32'd0);
    chk("idle_after_reset", {29'd0, state}, 32'd0);
    do_reset();

    // Start timeout, then busy rising on the last allowed cycle
    enable = 1'b1;
    fifo_full_count = 14'd4096;
    expect_ev(K_COLOR, 16'd0);
    expect_ev(K_ERR, 16'd0);
    wait_go("tmo_color_go", 1'b0, 1);
    fifo_full_count = '0;
    step(15);
    chk("tmo_still_start", {29'd0, state},     32'd1);
    chk("tmo_no_err_early", {31'd0, start_err}, 32'd0);
    step();
    chk("tmo_err_pulse",  {31'd0, start_err},   32'd1);
    chk("tmo_latch",      {29'd0, state},       32'd5);
    chk("tmo_frame_cnt",  {16'd0, frame_count}, 32'd0);
    chk("tmo_hold",       {31'd0, hold},        32'd1);
    do_reset();
    enable = 1'b1;
    fifo_full_count = 14'd4096;
    expect_ev(K_COLOR, 16'd0);
    wait_go("late_busy_go", 1'b0, 1);
    fifo_full_count = '0;
    step(15);
    color_busy = 1'b1;
    step();
    chk("late_busy_run",   {29'd0, state},     32'd2);
    chk("late_busy_noerr", {31'd0, start_err}, 32'd0);
    color_busy = 1'b0;
    step();
    chk("late_busy_frame", {16'd0, frame_count}, 32'd1);
    do_reset();

    // enable falls mid color run
    enable = 1'b1;
    fifo_full_count = 14'd4096;
    expect_ev(K_COLOR, 16'd0);
    wait_go("en_color_go", 1'b0, 1);
    color_busy = 1'b1;
    step(10);
    enable = 1'b0;
    step(10);
    chk("en_run_continues", {29'd0, state}, 32'd2);
    color_busy = 1'b0;
    step();
    chk("en_latch",     {29'd0, state},       32'd5);
    chk("en_frame_cnt", {16'd0, frame_count}, 32'd1);
    count_gos(6010, gos);
    chk("en_no_more_go", gos, 32'd0);
    chk("en_idle",       {29'd0, state}, 32'd0);

    w = 0;
    while (!wrap_done && w < 100000) begin
      step();
      w++;
    end
    chk("wrap_finished", {31'd0, wrap_done}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
